switch_debounce: RTL
====================

Name: switch_debounce

Overview:
- Input-conditioning stage directly upstream of the 2-bit adder top level.
- Takes the raw 5-bit slide-switch bus J1 (A = J1[1:0], B = J1[3:2], CIN = J1[4]).
- Synchronises and debounces each bit, then presents glitch-free operands to the adder.
- Adds a settle flag and a change strobe, so downstream logic and LEDs see only clean transitions.

Parameters:
- WIDTH, 5: number of switch bits conditioned.
- STABLE_CYCLES, 4: consecutive synchronised cycles a new level must hold before it is accepted. Legal range is 2 or more; a value below 2 is an elaboration error.
- CNT_W, $clog2(STABLE_CYCLES): per-bit counter width. Derived; never overridden.

Ports:
- CLK  input  1  single system clock; all state updates on the rising edge.
- RESETN  input  1  asynchronous, active-low reset.
- J1  input  WIDTH  raw switch levels, asynchronous to CLK.
- Q  output  WIDTH  debounced levels; feeds the adder operands.
- VALID  output  1  high when every bit is settled (no acceptance pending).
- CHANGED  output  1  one-cycle pulse in the first cycle Q shows a new value.

Behaviour:
- Reset (RESETN low, asynchronous, any time, including mid-count):
  - Sync stages, counters, Q, CHANGED and VALID all clear to 0.
  - Startup counter clears to 0.
  - Takes effect immediately, without waiting for a clock edge.
- Synchroniser: per bit, two flops in series, S1 then S2. S2 is the only version of J1 used internally.
- Per-bit counter, evaluated at each CLK edge:
  - S2 == Q: counter <= 0.
  - S2 != Q and counter < STABLE_CYCLES-1: counter increments.
  - S2 != Q and counter == STABLE_CYCLES-1: Q[i] <= S2[i] and counter <= 0.
  - Effect: acceptance requires STABLE_CYCLES consecutive mismatching S2 samples. Any return to Q's level restarts the count from 0.
  - The counter never wraps, because it is cleared at STABLE_CYCLES-1.
- Latency:
  - Raw level is set up before edge 0; S2 holds it after edge 1.
  - Q updates on edge STABLE_CYCLES+1, so it is visible STABLE_CYCLES+2 edges after the raw change.
  - With the default of 4: Q changes after edge 5.
- Glitch rejection: an S2 pulse shorter than STABLE_CYCLES cycles never reaches Q.
- Bit independence: bits are fully independent. Several bits may be accepted on the same edge.
- CHANGED:
  - Registered; high for exactly the one cycle following any edge that updated at least one Q bit.
  - Otherwise 0.
  - Back-to-back acceptances on consecutive edges hold CHANGED high across both cycles.
- VALID:
  - 0 while the startup counter is below 2, i.e. until two edges after RESETN deasserts, while the sync pipe fills.
  - After that, VALID = 1 exactly when all per-bit counters are 0 and S2 == Q. This is registered and visible one cycle after the condition.
  - VALID is 0 in any cycle in which some bit is counting.

Optional Feature:
- Macro: SWITCH_DEBOUNCE_EDGE_EN.
- Defined: two extra output ports, RISE (WIDTH) and FALL (WIDTH).
  - RISE[i] pulses for one cycle, aligned with CHANGED, when Q[i] went 0->1.
  - FALL[i] pulses likewise when Q[i] went 1->0.
  - Both reset to 0.
- Undefined: the ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package switch_debounce_pkg contains:
  - SW_WIDTH = 5.
  - SW_STABLE_DEFAULT = 4.
  - Field index constants A_LSB = 0, B_LSB = 2, CIN_BIT = 4, so the top level slices Q consistently.
- One sub-module, debounce_bit, covers the synchroniser, counter and output flop for a single bit. It is instantiated WIDTH times in a generate loop.
- The top level owns the startup counter, VALID, CHANGED, and RISE/FALL when enabled.

Test Plan (STABLE_CYCLES=4):
- Reset/startup: hold RESETN low, J1=5'b10101, then release.
  - Q=0, CHANGED=0 and VALID=0 during reset and for 2 edges after release.
  - Q=5'b10101 after edge 5 and CHANGED pulses once.
  - VALID=1 one cycle after Q settles.
- Latency: from settled Q=0, set J1=5'b00011 before edge 0.
  - Q=5'b00011 visible after edge 5, not earlier.
  - CHANGED high during exactly the cycle after edge 5.
- Glitch: J1[2] high for 3 cycles, then low.
  - Q stays 0; CHANGED never asserts; VALID drops while counting, then returns to 1.
- Bounce: toggle J1[4] 1,0,1,0,1 on consecutive cycles, then hold 1.
  - Q[4]=1 only after 4 consecutive synchronised 1s; exactly one CHANGED pulse.
- Mid-count reset: start J1=5'b11111 from Q=0 and assert RESETN at edge 3.
  - All outputs drop to 0 immediately, without waiting for a clock edge.
  - After release, acceptance restarts from zero count (Q after edge 5 relative to release).
- SWITCH_DEBOUNCE_EDGE_EN defined: change J1 from 5'b00001 to 5'b00010.
  - RISE=5'b00010 and FALL=5'b00001 pulse together with CHANGED for one cycle.

Source files
------------

// File: rtl/switch_debounce_pkg.sv
// Purpose: shared widths, defaults and operand field positions for the switch debouncer.
// Latency: none (constants only).
// Backpressure: none (constants only).
package switch_debounce_pkg;

    // Slide-switch bus as wired to J1: A = [1:0], B = [3:2], CIN = [4]
    localparam int SW_WIDTH          = 5;
    localparam int SW_STABLE_DEFAULT = 4;

    localparam int A_LSB   = 0;
    localparam int B_LSB   = 2;
    localparam int CIN_BIT = 4;

endpackage : switch_debounce_pkg

// File: rtl/debounce_bit.sv
// Purpose: two-flop synchroniser, stability counter and output flop for one switch bit.
// Latency: a raw change reaches q STABLE_CYCLES+2 edges later; shorter S2 pulses never reach q.
// Backpressure: none; free-running, always accepts input.
module debounce_bit
    import switch_debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = SW_STABLE_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic q,
    output logic accept,
    output logic idle
);

    localparam int                CNT_W    = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;

    // Bring the asynchronous switch level into the clock domain; only s2 is used beyond here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // Count consecutive mismatching samples; accept the new level on the last one, restart on any match.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            q   <= 1'b0;
        end else if (s2 == q) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            q   <= s2;
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // accept marks the edge on which q will flip; idle means nothing is pending for this bit.
    always_comb begin
        accept = (s2 != q) && (cnt == CNT_LAST);
        idle   = (s2 == q) && (cnt == '0);
    end

endmodule : debounce_bit

// File: rtl/switch_debounce.sv
// Purpose: debounce the J1 slide-switch bus into clean adder operands with settle flag and change strobe.
// Latency: Q follows a stable raw change after STABLE_CYCLES+2 edges; VALID/CHANGED are registered one cycle on.
// Backpressure: none; free-running. Optional RISE/FALL edge outputs when SWITCH_DEBOUNCE_EDGE_EN is defined.
module switch_debounce
    import switch_debounce_pkg::*;
#(
    parameter int WIDTH         = SW_WIDTH,
    parameter int STABLE_CYCLES = SW_STABLE_DEFAULT
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic [WIDTH-1:0] J1,
    output logic [WIDTH-1:0] Q,
    output logic             VALID,
    output logic             CHANGED
`ifdef SWITCH_DEBOUNCE_EDGE_EN
    ,
    output logic [WIDTH-1:0] RISE,
    output logic [WIDTH-1:0] FALL
`endif
);

    // A single-cycle stability window would make the counter zero bits wide and debounce nothing.
    if (STABLE_CYCLES < 2) begin : g_bad_stable
        $error("switch_debounce: STABLE_CYCLES must be 2 or more");
    end

    logic [WIDTH-1:0] accept;
    logic [WIDTH-1:0] idle;
    logic [1:0]       startup_cnt;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .STABLE_CYCLES (STABLE_CYCLES)
        ) u_bit (
            .clk    (CLK),
            .rst_n  (RESETN),
            .raw    (J1[i]),
            .q      (Q[i]),
            .accept (accept[i]),
            .idle   (idle[i])
        );
    end

    // Hold VALID off for the first two edges after reset while the sync pipe fills.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            startup_cnt <= 2'd0;
        end else if (startup_cnt != 2'd2) begin
            startup_cnt <= startup_cnt + 2'd1;
        end
    end

    // Settle flag and change strobe, both registered so they line up with the cycle Q shows its new value.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            VALID   <= 1'b0;
            CHANGED <= 1'b0;
        end else begin
            VALID   <= (startup_cnt == 2'd2) && (&idle);
            CHANGED <= |accept;
        end
    end

`ifdef SWITCH_DEBOUNCE_EDGE_EN
    // Per-bit direction of each acceptance; Q still holds the old level when accept is seen.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            RISE <= '0;
            FALL <= '0;
        end else begin
            RISE <= accept & ~Q;
            FALL <= accept & Q;
        end
    end
`endif

endmodule : switch_debounce
